// File: rtl/cache_pkg.sv
// Shared constants, AXI encodings and FSM state type for the cache line refill engine.
package cache_pkg;
  localparam int CACHE_LINE_SIZE = 512;
  localparam int BEATS           = CACHE_LINE_SIZE / 32;
  localparam int OFFSET_BITS     = $clog2(CACHE_LINE_SIZE / 8);
  localparam int WORD_IDX_BITS   = $clog2(BEATS);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, AR, RECV, DONE} refill_state_t;
endpackage

// File: rtl/refill_line_buf.sv
// Beat-indexed line assembly buffer; one word written per cycle, whole line read flat.
// No reset: contents are only consumed once every slot of the burst has been written.
module refill_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = cache_pkg::BEATS,
  parameter int IDX_W      = $clog2(BEATS)
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic [BEATS*DATA_WIDTH-1:0]   line_o
);
  logic [DATA_WIDTH-1:0] mem_q [BEATS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_flat
    assign line_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end
endmodule

// File: rtl/cache_line_refill.sv
// Miss refill engine: one INCR burst per accepted miss, beats assembled into a line,
// critical word forwarded one cycle after its beat. Outputs depend on state/registers only.
module cache_line_refill
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int Cache_line_size = CACHE_LINE_SIZE,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_req,
  input  logic [ADDR_WIDTH-1:0]      miss_addr,
  output logic                       miss_ready,
  output logic                       ar_valid,
  input  logic                       ar_ready,
  output logic [ADDR_WIDTH-1:0]      ar_addr,
  output logic [7:0]                 ar_len,
  output logic [2:0]                 ar_size,
  output logic [1:0]                 ar_burst,
  input  logic                       r_valid,
  output logic                       r_ready,
  input  logic [DATA_WIDTH-1:0]      r_data,
  input  logic                       r_last,
  input  logic [1:0]                 r_resp,
  output logic                       crit_valid,
  output logic [DATA_WIDTH-1:0]      crit_data,
  output logic                       line_valid,
  input  logic                       line_ack,
  output logic [Cache_line_size-1:0] line_data,
  output logic [ADDR_WIDTH-1:0]      line_addr,
  output logic                       line_err
);
  localparam int NBEATS = Cache_line_size / DATA_WIDTH;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(Cache_line_size / 8);
  localparam int SIZE_W = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  refill_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [IDX_W-1:0]            crit_idx_q, crit_idx_d;
  logic [IDX_W-1:0]            beat_q, beat_d;
  logic                        err_q, err_d;
  logic                        crit_vld_q, crit_vld_d;
  logic [DATA_WIDTH-1:0]       crit_data_q, crit_data_d;
  logic                        buf_we;
  logic [Cache_line_size-1:0]  buf_line;
  logic                        unused_addr_lsbs;

  // Byte-within-word bits never matter for a whole-word refill.
  assign unused_addr_lsbs = ^miss_addr[SIZE_W-1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    crit_idx_d  = crit_idx_q;
    beat_d      = beat_q;
    err_d       = err_q;
    crit_vld_d  = 1'b0;
    crit_data_d = crit_data_q;
    buf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          addr_d     = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          crit_idx_d = miss_addr[OFF_W-1:SIZE_W];
          beat_d     = '0;
          err_d      = 1'b0;
          state_d    = AR;
        end
      end
      AR: begin
        if (ar_ready) state_d = RECV;
      end
      RECV: begin
        if (r_valid) begin
          buf_we = 1'b1;
          if (r_resp != AXI_RESP_OKAY) err_d = 1'b1;
          if (beat_q == crit_idx_q) begin
            crit_vld_d  = 1'b1;
            crit_data_d = r_data;
          end
          // The beat count, not r_last, decides completion; a misplaced r_last only flags the line.
          if (beat_q == LAST_IDX) begin
            if (!r_last) err_d = 1'b1;
            state_d = DONE;
          end else begin
            if (r_last) err_d = 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (line_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      crit_idx_q  <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      crit_vld_q  <= 1'b0;
      crit_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      crit_idx_q  <= crit_idx_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      crit_vld_q  <= crit_vld_d;
      crit_data_q <= crit_data_d;
    end
  end

  refill_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (NBEATS),
    .IDX_W      (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .idx_i   (beat_q),
    .wdata_i (r_data),
    .line_o  (buf_line)
  );

  assign miss_ready = (state_q == IDLE);
  assign ar_valid   = (state_q == AR);
  assign r_ready    = (state_q == RECV);
  assign line_valid = (state_q == DONE);
  assign line_err   = (state_q == DONE) && err_q;
  assign ar_addr    = addr_q;
  assign line_addr  = addr_q;
  // Buffer has no reset, so the line is masked to zero outside DONE.
  assign line_data  = (state_q == DONE) ? buf_line : '0;
  assign crit_valid = crit_vld_q;
  assign crit_data  = crit_data_q;
  assign ar_len     = 8'(NBEATS - 1);
  assign ar_size    = 3'(SIZE_W);
  assign ar_burst   = AXI_BURST_INCR;
endmodule

// File: tb/tb_cache_line_refill.sv
// Scenario bench for cache_line_refill: expected beats/critical word queued as driven, compared on output.
module tb_cache_line_refill;
  logic         clk = 1'b0;
  logic         reset;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         ar_valid;
  logic         ar_ready = 1'b0;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [31:0]  r_data = '0;
  logic         r_last = 1'b0;
  logic [1:0]   r_resp = '0;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         line_valid;
  logic         line_ack = 1'b0;
  logic [511:0] line_data;
  logic [31:0]  line_addr;
  logic         line_err;

  cache_line_refill dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .r_valid(r_valid),
    .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .crit_valid(crit_valid), .crit_data(crit_data), .line_valid(line_valid),
    .line_ack(line_ack), .line_data(line_data), .line_addr(line_addr), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors, sampled on the falling edge.
  int          crit_cnt = 0, crit_cyc_obs = 0, ar_rise = 0;
  logic [31:0] crit_obs = '0;
  logic        prev_arv = 1'b0;
  always @(negedge clk) begin
    if (crit_valid) begin
      crit_cnt++;
      crit_cyc_obs = cyc;
      crit_obs = crit_data;
    end
    if (ar_valid && !prev_arv) ar_rise++;
    prev_arv = ar_valid;
  end

  // Scoreboard and per-burst observations.
  logic [31:0]  exp_words[$];
  logic [31:0]  exp_crit[$];
  int           exp_crit_cyc, acc_cyc, line_cyc, done_cyc;
  logic [511:0] line_snap;
  logic [31:0]  laddr_snap, ar_seen_addr;
  logic         err_snap, ar_stable, lv_held, mr_after, early_lv, ar_seen_vld;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_burst(input logic [31:0] addr, input logic [31:0] dbase, input int ar_dly,
                             input bit gap, input int err_beat, input int last_beat,
                             input int ack_dly, input bit hold);
    int k, guard, cidx;
    bit ph;
    logic [31:0] aligned;
    aligned = {addr[31:6], 6'b0};
    cidx = int'(addr[5:2]);
    exp_words.delete();
    exp_crit.delete();
    miss_req = 1'b1;
    miss_addr = addr;
    guard = 0;
    while (!miss_ready && guard < 200) begin step(); guard++; end
    acc_cyc = cyc;
    step();
    miss_req = hold;
    ar_stable = 1'b1;
    for (int i = 0; i < ar_dly; i++) begin
      ar_ready = 1'b0;
      if (!ar_valid || ar_addr !== aligned) ar_stable = 1'b0;
      step();
    end
    ar_ready = 1'b1;
    ar_seen_addr = ar_addr;
    ar_seen_vld = ar_valid;
    step();
    ar_ready = 1'b0;
    k = 0; ph = 1'b0; guard = 0; early_lv = 1'b0;
    while (k < 16 && guard < 200) begin
      if (line_valid) early_lv = 1'b1;
      r_data  = dbase + 32'(k);
      r_last  = (k == last_beat);
      r_resp  = (k == err_beat) ? 2'b10 : 2'b00;
      r_valid = !(gap && ph);
      ph = !ph;
      if (r_valid && r_ready) begin
        exp_words.push_back(dbase + 32'(k));
        if (k == cidx) begin
          exp_crit.push_back(dbase + 32'(k));
          exp_crit_cyc = cyc + 1;
        end
        k++;
      end
      step();
      guard++;
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    guard = 0;
    while (!line_valid && guard < 50) begin step(); guard++; end
    line_cyc = cyc;
    line_snap = line_data;
    err_snap = line_err;
    laddr_snap = line_addr;
    lv_held = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      if (!line_valid || line_data !== line_snap || line_addr !== laddr_snap || line_err !== err_snap)
        lv_held = 1'b0;
      step();
    end
    if (!line_valid) lv_held = 1'b0;
    line_ack = 1'b1;
    step();
    line_ack = 1'b0;
    done_cyc = cyc;
    mr_after = miss_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL rst_miss_ready got %b want 1", miss_ready); end
    n_vec++; if ({ar_valid, r_ready, crit_valid, line_valid, line_err} !== 5'b0) begin n_err++;
      $display("FAIL rst_ctrl got %b want 00000", {ar_valid, r_ready, crit_valid, line_valid, line_err}); end
    n_vec++; if (ar_addr !== 32'h0 || line_addr !== 32'h0) begin n_err++;
      $display("FAIL rst_addr got %h/%h want 0/0", ar_addr, line_addr); end
    n_vec++; if (line_data !== 512'h0 || crit_data !== 32'h0) begin n_err++;
      $display("FAIL rst_data got crit %h line_nonzero=%b want 0", crit_data, |line_data); end
    reset = 1'b0;
    step();
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_idle got %b want 1", miss_ready); end
  endtask

  task automatic test_aligned();
    int c0;
    logic [31:0] w;
    c0 = crit_cnt;
    drive_burst(32'h8000_0040, 32'h1000, 0, 1'b0, 99, 15, 0, 1'b0);
    n_vec++; if (ar_seen_addr !== 32'h8000_0040 || ar_seen_vld !== 1'b1) begin n_err++;
      $display("FAIL al_ar_addr got %h vld %b want 80000040 vld 1", ar_seen_addr, ar_seen_vld); end
    n_vec++; if ({ar_len, ar_size, ar_burst} !== {8'd15, 3'd2, 2'b01}) begin n_err++;
      $display("FAIL al_ar_fields got len %0d size %0d burst %0d want 15 2 1", ar_len, ar_size, ar_burst); end
    n_vec++; if (line_cyc - acc_cyc !== 18 || early_lv) begin n_err++;
      $display("FAIL al_line_latency got %0d early %b want 18", line_cyc - acc_cyc, early_lv); end
    for (int k = 0; k < 16; k++) begin
      w = (exp_words.size() > 0) ? exp_words.pop_front() : 32'hDEAD_BEEF;
      n_vec++; if (line_snap[k*32 +: 32] !== w) begin n_err++;
        $display("FAIL al_word%0d got %h want %h", k, line_snap[k*32 +: 32], w); end
    end
    n_vec++; if (err_snap !== 1'b0 || laddr_snap !== 32'h8000_0040) begin n_err++;
      $display("FAIL al_err_addr got err %b addr %h want 0 80000040", err_snap, laddr_snap); end
    n_vec++; if (done_cyc - acc_cyc !== 19 || mr_after !== 1'b1) begin n_err++;
      $display("FAIL al_ready_after got cyc %0d rdy %b want 19 1", done_cyc - acc_cyc, mr_after); end
    w = (exp_crit.size() > 0) ? exp_crit.pop_front() : 32'hDEAD_BEEF;
    n_vec++; if (crit_cnt - c0 !== 1 || crit_obs !== w || crit_cyc_obs - acc_cyc !== 3) begin n_err++;
      $display("FAIL al_crit0 got n %0d data %h lat %0d want 1 %h 3", crit_cnt - c0, crit_obs, crit_cyc_obs - acc_cyc, w); end
  endtask

  task automatic test_crit();
    int c0;
    logic [31:0] base, w;
    c0 = crit_cnt;
    base = $urandom;
    drive_burst(32'h0000_107C, base, 0, 1'b0, 99, 15, 0, 1'b0);
    w = (exp_crit.size() > 0) ? exp_crit.pop_front() : ~base;
    n_vec++; if (crit_cnt - c0 !== 1) begin n_err++; $display("FAIL cr_pulses got %0d want 1", crit_cnt - c0); end
    n_vec++; if (crit_obs !== w || crit_cyc_obs !== exp_crit_cyc || crit_cyc_obs - acc_cyc !== 18) begin n_err++;
      $display("FAIL cr_word got %h at %0d want %h at %0d", crit_obs, crit_cyc_obs - acc_cyc, w, 18); end
    n_vec++; if (ar_seen_addr !== 32'h0000_1040) begin n_err++;
      $display("FAIL cr_ar_addr got %h want 00001040", ar_seen_addr); end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [31:0] w;
    drive_burst(32'h1234_56A4, 32'hA500_0000, 5, 1'b1, 99, 15, 4, 1'b0);
    n_vec++; if (!ar_stable || ar_seen_addr !== 32'h1234_5680) begin n_err++;
      $display("FAIL bp_ar_hold got stable %b addr %h want 1 12345680", ar_stable, ar_seen_addr); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      w = (exp_words.size() > 0) ? exp_words.pop_front() : 32'hDEAD_BEEF;
      if (line_snap[k*32 +: 32] !== w) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_line got %0d bad words want 0", bad); end
    n_vec++; if (!lv_held || mr_after !== 1'b1 || err_snap !== 1'b0) begin n_err++;
      $display("FAIL bp_line_hold got held %b rdy %b err %b want 1 1 0", lv_held, mr_after, err_snap); end
  endtask

  task automatic test_errors();
    drive_burst(32'h0000_2000, 32'h3000, 0, 1'b0, 3, 15, 0, 1'b0);
    n_vec++; if (err_snap !== 1'b1) begin n_err++; $display("FAIL er_resp got %b want 1", err_snap); end
    drive_burst(32'h0000_3000, 32'h4000, 0, 1'b0, 99, 7, 0, 1'b0);
    n_vec++; if (err_snap !== 1'b1 || early_lv || exp_words.size() != 16 || line_cyc - acc_cyc !== 18) begin n_err++;
      $display("FAIL er_early_last got err %b early %b beats %0d lat %0d want 1 0 16 18",
               err_snap, early_lv, exp_words.size(), line_cyc - acc_cyc); end
    drive_burst(32'h0000_4000, 32'h5000, 0, 1'b0, 99, 99, 0, 1'b0);
    n_vec++; if (err_snap !== 1'b1) begin n_err++; $display("FAIL er_missing_last got %b want 1", err_snap); end
    drive_burst(32'h0000_5000, 32'h6000, 0, 1'b0, 99, 15, 0, 1'b0);
    n_vec++; if (err_snap !== 1'b0) begin n_err++; $display("FAIL er_cleared got %b want 0", err_snap); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    int bad;
    miss_req = 1'b1;
    miss_addr = 32'h0000_6018;
    step();
    miss_req = 1'b0;
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    r_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      r_data = 32'h7700 + 32'(k);
      step();
    end
    r_valid = 1'b0;
    n_vec++; if (crit_valid !== 1'b1 || crit_data !== 32'h7706) begin n_err++;
      $display("FAIL rm_crit_pre got %b %h want 1 00007706", crit_valid, crit_data); end
    reset = 1'b1;
    #1;
    n_vec++; if ({miss_ready, r_ready, crit_valid, line_valid} !== 4'b1000) begin n_err++;
      $display("FAIL rm_state got %b want 1000", {miss_ready, r_ready, crit_valid, line_valid}); end
    step();
    reset = 1'b0;
    step();
    drive_burst(32'h0000_7000, 32'h8800, 0, 1'b0, 99, 15, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      w = (exp_words.size() > 0) ? exp_words.pop_front() : 32'hDEAD_BEEF;
      if (line_snap[k*32 +: 32] !== w) bad++;
    end
    n_vec++; if (bad != 0 || err_snap !== 1'b0 || line_cyc - acc_cyc !== 18) begin n_err++;
      $display("FAIL rm_clean got bad %0d err %b lat %0d want 0 0 18", bad, err_snap, line_cyc - acc_cyc); end
  endtask

  task automatic test_back_to_back();
    int a0, first_done;
    a0 = ar_rise;
    drive_burst(32'h0000_9000, 32'h9000, 0, 1'b0, 99, 15, 2, 1'b1);
    first_done = done_cyc;
    n_vec++; if (ar_rise - a0 !== 1) begin n_err++; $display("FAIL bb_single_ar got %0d want 1", ar_rise - a0); end
    n_vec++; if (mr_after !== 1'b1) begin n_err++; $display("FAIL bb_ready got %b want 1", mr_after); end
    drive_burst(32'h0000_9000, 32'hB000, 0, 1'b0, 99, 15, 0, 1'b0);
    n_vec++; if (acc_cyc !== first_done || ar_rise - a0 !== 2) begin n_err++;
      $display("FAIL bb_accept got cyc %0d ars %0d want %0d 2", acc_cyc, ar_rise - a0, first_done); end
    n_vec++; if (line_snap[15*32 +: 32] !== 32'hB00F || err_snap !== 1'b0) begin n_err++;
      $display("FAIL bb_line got %h err %b want 0000b00f 0", line_snap[15*32 +: 32], err_snap); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_crit();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Cache miss refill engine between the cache controller and the AXI read channel. On an accepted miss it issues one INCR burst for the line-aligned address and assembles the returned beats into a full cache line. The line is presented on a valid/ack port that writes the data/tag Sramlike arrays. The critical (missed) word is forwarded as soon as its beat arrives, for early restart.

## Interface
- DATA_WIDTH, 32: AXI data / cache word width in bits.
- Cache_line_size, 512: line width in bits; BEATS = Cache_line_size/DATA_WIDTH (16).
- ADDR_WIDTH, 32: physical address width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- miss_req  in  1  miss request from cache controller.
- miss_addr  in  ADDR_WIDTH  byte address of missing access.
- miss_ready  out  1  engine idle; the request is accepted when miss_req && miss_ready.
- ar_valid / ar_ready  out / in  1  AXI read address handshake.
- ar_addr  out  ADDR_WIDTH  miss_addr with the low log2(Cache_line_size/8) bits cleared.
- ar_len  out  8  constant BEATS-1.
- ar_size  out  3  constant log2(DATA_WIDTH/8).
- ar_burst  out  2  constant 2'b01 (INCR).
- r_valid / r_ready  in / out  1  AXI read data handshake.
- r_data  in  DATA_WIDTH  beat data.
- r_last  in  1  final beat marker.
- r_resp  in  2  beat response; nonzero = error.
- crit_valid  out  1  one-cycle pulse: critical word available.
- crit_data  out  DATA_WIDTH  critical word.
- line_valid / line_ack  out / in  1  assembled line handshake.
- line_data  out  Cache_line_size  assembled line; beat k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- line_addr  out  ADDR_WIDTH  line-aligned address (same value as ar_addr).
- line_err  out  1  a response error or r_last protocol error occurred during the burst.

## Operation
- FSM states: IDLE, AR, RECV, DONE. Reset state is IDLE.
- IDLE
  - miss_ready=1.
  - On accept: latch the aligned address and the critical word index (miss_addr bits [log2(Cache_line_size/8)-1 : log2(DATA_WIDTH/8)]); clear beat_cnt and err; go to AR.
- AR
  - ar_valid=1; hold ar_addr stable until ar_ready.
  - On handshake go to RECV.
- RECV
  - r_ready=1.
  - Each r handshake writes r_data into slot beat_cnt, then increments beat_cnt (4 bits, no wrap beyond BEATS-1).
  - r_resp != 0 sets err (sticky for the burst).
  - Beat with beat_cnt == crit index: crit_data = r_data and crit_valid=1 on the next cycle only.
  - Completion is taken on the handshake with beat_cnt == BEATS-1, regardless of r_last.
  - r_last asserted with beat_cnt != BEATS-1, or deasserted on beat BEATS-1, sets err. In the early-r_last case the engine keeps counting until beat BEATS-1.
  - On completion go to DONE.
- DONE
  - line_valid=1; line_data, line_addr and line_err are held stable.
  - On line_ack go to IDLE.
- line_err = err while in DONE, 0 otherwise.
- A miss_req arriving outside IDLE is ignored (miss_ready=0); the controller holds it.
- Reset mid-burst: return to IDLE immediately and clear beat_cnt, err and crit_valid. Discarding stray beats is the interconnect's concern; r_ready is 0 in IDLE.

## Timing
- Reset values:
  - miss_ready=1.
  - ar_valid, r_ready, crit_valid, line_valid, line_err = 0.
  - ar_addr, line_addr, line_data, crit_data = 0.
- All outputs are registered or decoded from state only. There is no combinational path from AXI inputs to outputs.
- Best case (ar_ready=1 and r_valid=1 every cycle):
  - accept at cycle 0
  - ar_valid cycle 1
  - beats cycles 2–17
  - line_valid cycle 18
  - miss_ready cycle 19 if line_ack is asserted at cycle 18.
- crit_valid asserts exactly 1 cycle after the critical beat handshake. Latency is 3 cycles after accept for crit index 0, and 18 cycles for index 15.
- Back-to-back misses: a new miss can be accepted in the first IDLE cycle after line_ack.
- r_valid gaps stall beat_cnt; no timeout.

## Structure
- Shared package cache_pkg holds:
  - CACHE_LINE_SIZE, BEATS, OFFSET_BITS, WORD_IDX_BITS
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00
  - refill_state_t enum (IDLE, AR, RECV, DONE).
- One sub-module, refill_line_buf: the BEATS×DATA_WIDTH register array with an indexed write port (we, idx, wdata) and a flat Cache_line_size read-out. It has no reset; contents are only meaningful when line_valid=1.

## Test plan
- Aligned miss: miss_addr=0x8000_0040, ar_ready immediate, 16 beats with data 0x1000+k, r_last on beat 15.
  - ar_addr=0x8000_0040, ar_len=15, ar_size=2, ar_burst=1.
  - line_valid at cycle 18, line_data word k = 0x1000+k, line_err=0.
- Critical word: miss_addr=0x0000_107C (word 15).
  - crit_valid pulses once, 1 cycle after beat 15, with crit_data = beat 15 data.
- Backpressure: ar_ready delayed 5 cycles; r_valid low on alternate cycles.
  - ar_addr is held stable throughout and the line is correct.
  - line_valid stays high for 4 cycles until line_ack, then miss_ready=1 on the next cycle.
- Errors: r_resp=2'b10 on beat 3 -> line_err=1 in DONE. In a separate burst, r_last on beat 7 -> line_err=1, and completion still occurs after 16 beats.
- Reset mid-burst: assert reset after beat 6.
  - Next cycle: IDLE, miss_ready=1, r_ready=0, crit_valid=0.
  - A new miss completes cleanly with line_err=0.
- Ignored request: miss_req held during RECV.
  - No second AR is issued; the request is accepted in the first IDLE cycle after line_ack.
